// File: rtl/irq_ctrl.sv
// ----------------------------------------------------------------------------
// irq_ctrl : 8-source interrupt controller for the cpu68 irq input.
//
// Asynchronous request lines are synchronised, turned into pending events
// (rising-edge or level, per source), masked, priority-encoded and combined
// into a single registered, active-high irq. The CPU sees a 16-byte register
// window using the same bus protocol as simpleio.
//
// Ports:
//   clk      in   1  system clock, all state updates on posedge
//   b_reset  in   1  asynchronous, active-low reset
//   Address  in   4  register select
//   DI       in   8  write data from CPU
//   DO       out  8  read data to CPU, combinational from Address
//   rw       in   1  1 = read, 0 = write
//   cs       in   1  window select; write occurs when cs && !rw at posedge
//   src      in   8  asynchronous interrupt requests, active-high
//   irq      out  1  interrupt to CPU, active-high, registered
//
// Register map:
//   0 PEND  R pending / W 1-to-clear
//   1 MASK  R/W source enable
//   2 EDGE  R/W 1 = rising-edge mode, 0 = level mode
//   3 CTRL  R/W bit0 = global interrupt enable
//   4 SWSET W 1-to-set pending (reads 0x00)
//   5 VEC   R bit7 = no active source, bits[2:0] = lowest active index
//   6 RAW   R synchronised source levels
//   7..15   R 0xFF, writes ignored
// ----------------------------------------------------------------------------
module irq_ctrl #(
    parameter int NSRC     = 8,
    parameter int SYNC_LEN = 2
) (
    input  logic            clk,
    input  logic            b_reset,
    input  logic [3:0]      Address,
    input  logic [7:0]      DI,
    output logic [7:0]      DO,
    input  logic            rw,
    input  logic            cs,
    input  logic [NSRC-1:0] src,
    output logic            irq
);

    localparam logic [3:0] A_PEND  = 4'd0;
    localparam logic [3:0] A_MASK  = 4'd1;
    localparam logic [3:0] A_EDGE  = 4'd2;
    localparam logic [3:0] A_CTRL  = 4'd3;
    localparam logic [3:0] A_SWSET = 4'd4;
    localparam logic [3:0] A_VEC   = 4'd5;
    localparam logic [3:0] A_RAW   = 4'd6;

    logic [NSRC-1:0] sync_q [SYNC_LEN];
    logic [NSRC-1:0] s;
    logic [NSRC-1:0] prev_q;
    logic [NSRC-1:0] pend_q;
    logic [NSRC-1:0] pend_d;
    logic [NSRC-1:0] mask_q;
    logic [NSRC-1:0] edge_q;
    logic            gie_q;

    logic            wr;
    logic [NSRC-1:0] swset;
    logic [NSRC-1:0] w1c;
    logic [NSRC-1:0] set_event;
    logic [NSRC-1:0] active;
    logic            any_active;
    logic [2:0]      vec_idx;

    assign s  = sync_q[SYNC_LEN-1];
    assign wr = cs && !rw;

    // ---- Synchroniser and previous-level tracking ----
    // prev follows s regardless of mode, so flipping a source into edge mode
    // while it is already high does not look like a rising edge.
    always_ff @(posedge clk or negedge b_reset) begin
        if (!b_reset) begin
            for (int i = 0; i < SYNC_LEN; i++) begin
                sync_q[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= src;
            for (int i = 1; i < SYNC_LEN; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= s;
        end
    end

    // ---- Pending event logic ----
    // Set beats clear: a level source still high, or an edge arriving in the
    // same cycle as a W1C, keeps its pending bit.
    always_comb begin
        swset     = (wr && Address == A_SWSET) ? DI[NSRC-1:0] : '0;
        w1c       = (wr && Address == A_PEND)  ? DI[NSRC-1:0] : '0;
        set_event = (edge_q & s & ~prev_q) | (~edge_q & s) | swset;
        pend_d    = set_event | (pend_q & ~w1c);
    end

    always_ff @(posedge clk or negedge b_reset) begin
        if (!b_reset) begin
            pend_q <= '0;
            mask_q <= '0;
            edge_q <= '0;
            gie_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            if (wr && Address == A_MASK) begin
                mask_q <= DI[NSRC-1:0];
            end
            if (wr && Address == A_EDGE) begin
                edge_q <= DI[NSRC-1:0];
            end
            if (wr && Address == A_CTRL) begin
                gie_q <= DI[0];
            end
        end
    end

    // ---- Masking and priority encode (bit 0 highest priority) ----
    // Masking happens only here; masked sources still latch into PEND.
    always_comb begin
        active     = pend_q & mask_q;
        any_active = |active;
        vec_idx    = 3'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (active[i]) begin
                vec_idx = 3'(i);
            end
        end
    end

    // ---- Registered interrupt output ----
    always_ff @(posedge clk or negedge b_reset) begin
        if (!b_reset) begin
            irq <= 1'b0;
        end else begin
            irq <= gie_q & any_active;
        end
    end

    // ---- Read mux (independent of cs; chip select muxing is upstream) ----
    always_comb begin
        DO = 8'hFF;
        case (Address)
            A_PEND:  DO = pend_q;
            A_MASK:  DO = mask_q;
            A_EDGE:  DO = edge_q;
            A_CTRL:  DO = {7'b0, gie_q};
            A_SWSET: DO = 8'h00;
            A_VEC:   DO = any_active ? {5'b0, vec_idx} : 8'h80;
            A_RAW:   DO = s;
            default: DO = 8'hFF;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl. Inputs change on the falling edge, outputs
// are checked shortly after the falling edge.
module tb_irq_ctrl;

    logic       clk;
    logic       b_reset;
    logic [3:0] Address;
    logic [7:0] DI;
    logic [7:0] DO;
    logic       rw;
    logic       cs;
    logic [7:0] src;
    logic       irq;

    int tests;
    int fails;

    irq_ctrl #(.NSRC(8), .SYNC_LEN(2)) dut (
        .clk     (clk),
        .b_reset (b_reset),
        .Address (Address),
        .DI      (DI),
        .DO      (DO),
        .rw      (rw),
        .cs      (cs),
        .src     (src),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; the write happens on the next rising edge and
    // the task returns at the falling edge after it.
    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        Address = a;
        DI      = d;
        rw      = 1'b0;
        cs      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cs      = 1'b0;
        rw      = 1'b1;
        DI      = 8'h00;
    endtask

    task automatic rd(input string tag, input logic [3:0] a, input logic [7:0] exp);
        Address = a;
        rw      = 1'b1;
        #1;
        chk(tag, DO, exp);
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        #1;
        chk(tag, {7'b0, irq}, {7'b0, exp});
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        b_reset = 1'b0;
        Address = 4'd0;
        DI      = 8'h00;
        rw      = 1'b1;
        cs      = 1'b0;
        src     = 8'h00;

        cycles(2);
        chk_irq("rst_irq", 1'b0);
        rd("rst_pend", 4'd0, 8'h00);
        rd("rst_vec", 4'd5, 8'h80);
        b_reset = 1'b1;
        cycles(1);

        // Edge mode on source 0
        wr(4'd2, 8'h01);
        wr(4'd1, 8'h01);
        wr(4'd3, 8'hFF);
        rd("ctrl_ro_bits", 4'd3, 8'h01);
        src = 8'h01;                 // rising edge N follows
        cycles(2);                   // past N and N+1
        rd("edge_pend_n1", 4'd0, 8'h00);
        cycles(1);                   // past N+2
        rd("edge_pend_n2", 4'd0, 8'h01);
        chk_irq("edge_irq_n2", 1'b0);
        cycles(1);                   // past N+3
        chk_irq("edge_irq_n3", 1'b1);
        rd("edge_raw", 4'd6, 8'h01);
        wr(4'd0, 8'h01);             // W1C while src stays high
        rd("edge_w1c_pend", 4'd0, 8'h00);
        cycles(1);
        chk_irq("edge_w1c_irq", 1'b0);
        cycles(3);
        rd("edge_no_retrig", 4'd0, 8'h00);

        // Level mode on source 2
        src = 8'h00;
        cycles(3);
        wr(4'd2, 8'h00);
        wr(4'd1, 8'h04);
        wr(4'd0, 8'hFF);
        rd("lvl_clear", 4'd0, 8'h00);
        src = 8'h04;
        cycles(4);
        rd("lvl_pend", 4'd0, 8'h04);
        chk_irq("lvl_irq", 1'b1);
        wr(4'd0, 8'h04);
        rd("lvl_w1c_held", 4'd0, 8'h04);
        src = 8'h00;
        cycles(3);
        wr(4'd0, 8'h04);
        rd("lvl_w1c_pend", 4'd0, 8'h00);
        cycles(1);
        chk_irq("lvl_irq_low", 1'b0);

        // Priority and masking with software-set pending bits
        wr(4'd4, 8'hA4);
        rd("swset_rd", 4'd4, 8'h00);
        rd("swset_pend", 4'd0, 8'hA4);
        wr(4'd1, 8'hA0);
        rd("vec_a0", 4'd5, 8'h05);
        wr(4'd1, 8'h80);
        rd("vec_80", 4'd5, 8'h07);
        wr(4'd1, 8'h00);
        rd("vec_none", 4'd5, 8'h80);
        cycles(1);
        chk_irq("mask0_irq", 1'b0);
        rd("mask0_pend", 4'd0, 8'hA4);

        // Edge arriving in the same cycle as its W1C; GIE off
        wr(4'd0, 8'hFF);
        wr(4'd2, 8'h08);
        wr(4'd1, 8'h08);
        wr(4'd3, 8'h00);
        rd("coll_pre", 4'd0, 8'h00);
        src = 8'h08;                 // rising edge N follows
        cycles(2);
        wr(4'd0, 8'h08);             // W1C on edge N+2, same cycle as set
        rd("coll_pend", 4'd0, 8'h08);
        cycles(2);
        chk_irq("gie0_irq", 1'b0);
        wr(4'd3, 8'h01);
        chk_irq("gie_wr_edge", 1'b0);
        cycles(1);
        chk_irq("gie_on_irq", 1'b1);

        // Unmapped addresses
        for (int a = 7; a < 16; a++) begin
            rd($sformatf("unmapped_%0d", a), 4'(a), 8'hFF);
        end
        wr(4'd9, 8'h55);
        rd("dec_pend", 4'd0, 8'h08);
        rd("dec_mask", 4'd1, 8'h08);
        rd("dec_edge", 4'd2, 8'h08);
        rd("dec_ctrl", 4'd3, 8'h01);

        // Reset in the middle of activity
        wr(4'd4, 8'h30);
        #2;
        b_reset = 1'b0;
        chk_irq("mid_rst_irq", 1'b0);
        rd("mid_rst_pend", 4'd0, 8'h00);
        rd("mid_rst_mask", 4'd1, 8'h00);
        rd("mid_rst_edge", 4'd2, 8'h00);
        rd("mid_rst_ctrl", 4'd3, 8'h00);
        rd("mid_rst_vec", 4'd5, 8'h80);
        rd("mid_rst_raw", 4'd6, 8'h00);
        src = 8'h00;
        cycles(2);
        b_reset = 1'b1;
        cycles(2);
        rd("post_rst_pend", 4'd0, 8'h00);
        chk_irq("post_rst_irq", 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
